pipeline_if_id_elastic: RTL and testbench
=========================================

Name: pipeline_if_id_elastic

Overview:
Parametrised successor to the fixed IF/ID pipeline register. It carries an instruction word and its PC+4 from fetch to decode. It adds a valid/ready handshake with a one-entry skid buffer, a synchronous flush for branch redirect, NOP bubble insertion, and a saturating bubble counter. It sits between the instruction-fetch stage and the decode stage, and obeys the global memory BUSY_WAIT freeze.

Parameters:
INSTR_W, 32, instruction word width
PC_W, 32, PC+4 field width
NOP_INSTR, 32'h00000013, bubble/reset instruction value (addi x0,x0,0), INSTR_W bits
RESET_PC4, 32'hFFFFFFFC, PC_INCREMENT4_OUT value after reset (-4), PC_W bits
CNT_W, 16, bubble counter width

Ports:
CLK  input  1  clock; all state updates on posedge
RESET  input  1  synchronous, active-high reset
BUSY_WAIT  input  1  global memory stall; freezes all state
FLUSH  input  1  branch redirect; kills all held entries
IN_VALID  input  1  fetch presents a valid instruction
IN_READY  output  1  stage can accept; registered, equals !skid_valid
INSTRUCTION  input  INSTR_W  fetched instruction
PC_INCREMENT4  input  PC_W  PC+4 of fetched instruction
OUT_VALID  output  1  decode-side entry valid
OUT_READY  input  1  decode can consume (low on hazard stall)
INSTRUCTION_OUT  output  INSTR_W  main-entry instruction, or NOP_INSTR when empty
PC_INCREMENT4_OUT  output  PC_W  main-entry PC+4
OCCUPANCY  output  2  entries held: 0, 1 or 2
BUBBLE_COUNT  output  CNT_W  saturating count of bubble cycles

Behaviour:
- Storage: main entry (drives outputs) plus skid entry. States: EMPTY (0), FULL (1, main valid), SKID (2, both valid). OUT_VALID = main_valid. OCCUPANCY = state. All outputs are registered; there are no combinational in-to-out paths.
- in_fire = IN_VALID & IN_READY & !BUSY_WAIT. out_fire = OUT_VALID & OUT_READY & !BUSY_WAIT.
- Priority per edge: RESET > FLUSH > BUSY_WAIT > handshake.
- RESET:
  - state EMPTY, IN_READY=1, OUT_VALID=0.
  - INSTRUCTION_OUT=NOP_INSTR, PC_INCREMENT4_OUT=RESET_PC4.
  - BUBBLE_COUNT=0, skid contents don't-care.
- FLUSH (overrides BUSY_WAIT):
  - state EMPTY, INSTRUCTION_OUT=NOP_INSTR, PC_INCREMENT4_OUT holds.
  - Any same-cycle in_fire is discarded. BUBBLE_COUNT unchanged.
- BUSY_WAIT=1 (no flush/reset): every register holds, including BUBBLE_COUNT.
- Transitions (no reset/flush/busy):
  - EMPTY, in_fire -> FULL; main <= inputs.
  - FULL, in_fire & !out_fire -> SKID; skid <= inputs; IN_READY falls next cycle.
  - FULL, in_fire & out_fire -> FULL; main <= inputs.
  - FULL, !in_fire & out_fire -> EMPTY; INSTRUCTION_OUT <= NOP_INSTR, PC holds.
  - SKID, out_fire -> FULL; main <= skid; IN_READY rises next cycle.
  - Otherwise hold.
- Latency: one cycle from in_fire to OUT_VALID when the stage is empty. Throughput is 1 per cycle with OUT_READY high.
- No loss: IN_READY is registered, so an upstream that sees IN_READY=1 for one cycle after a downstream stall is absorbed by the skid entry.
- BUBBLE_COUNT: increments on cycles with OUT_READY=1, OUT_VALID=0, BUSY_WAIT=0, RESET=0, FLUSH=0. It saturates at 2^CNT_W-1 and does not wrap.
- Width rules: inputs and outputs are passed through unmodified. No arithmetic is performed on PC.

Test Plan:
- Reset for 2 cycles, then release -> OUT_VALID=0, INSTRUCTION_OUT=00000013, PC_INCREMENT4_OUT=FFFFFFFC, IN_READY=1, OCCUPANCY=0, BUBBLE_COUNT counting from 0 with OUT_READY=1.
- Stream instr A..D (PC4 4,8,C,10), IN_VALID=OUT_READY=1 -> each appears one cycle later, back-to-back, OCCUPANCY=1 throughout.
- Downstream stall: drop OUT_READY after A is output while B is presented -> B goes to skid, OCCUPANCY=2, IN_READY=0. Raise OUT_READY -> B then C output in order, no loss or duplication.
- BUSY_WAIT=1 for 3 cycles mid-stream with IN_VALID=OUT_READY=1 -> all outputs, OCCUPANCY and BUBBLE_COUNT frozen. Release -> stream resumes unchanged.
- FLUSH in SKID state concurrent with BUSY_WAIT=1 and IN_VALID=1 -> next cycle OCCUPANCY=0, OUT_VALID=0, INSTRUCTION_OUT=00000013, IN_READY=1, incoming word dropped.
- CNT_W=2, 5 empty cycles with OUT_READY=1 -> BUBBLE_COUNT 1,2,3,3,3 (saturates, no wrap).

Source files
------------

// File: rtl/pipeline_if_id_elastic.sv
// IF/ID elastic pipeline register.
// Carries the fetched instruction word and its PC+4 from fetch to decode
// through a valid/ready handshake. A one-entry skid buffer absorbs the word
// that upstream may still launch in the cycle after decode stalls, because
// IN_READY is registered. FLUSH (branch redirect) empties the stage. The
// global BUSY_WAIT freezes every register. BUBBLE_COUNT is a saturating count
// of cycles in which decode was ready but had nothing to consume.
module pipeline_if_id_elastic #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013,
    parameter logic [PC_W-1:0]    RESET_PC4 = 32'hFFFFFFFC,
    parameter int                 CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BUSY_WAIT,
    input  logic               FLUSH,
    input  logic               IN_VALID,
    output logic               IN_READY,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic [PC_W-1:0]    PC_INCREMENT4,
    output logic               OUT_VALID,
    input  logic               OUT_READY,
    output logic [INSTR_W-1:0] INSTRUCTION_OUT,
    output logic [PC_W-1:0]    PC_INCREMENT4_OUT,
    output logic [1:0]         OCCUPANCY,
    output logic [CNT_W-1:0]   BUBBLE_COUNT
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic               in_ready_q,   in_ready_d;
    logic               out_valid_q,  out_valid_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    main_pc4_q,   main_pc4_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic [PC_W-1:0]    skid_pc4_q,   skid_pc4_d;
    logic [CNT_W-1:0]   bubble_q,     bubble_d;

    logic in_fire;
    logic out_fire;
    logic bubble_cycle;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] max_val;
        max_val = {CNT_W{1'b1}};
        if (value == max_val) begin
            return value;
        end
        return value + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Handshake qualifiers; a frozen pipeline neither accepts nor delivers.
    always_comb begin
        in_fire      = IN_VALID & in_ready_q & ~BUSY_WAIT;
        out_fire     = out_valid_q & OUT_READY & ~BUSY_WAIT;
        bubble_cycle = OUT_READY & ~out_valid_q & ~BUSY_WAIT & ~FLUSH;
    end

    // Next-state and datapath selection: FLUSH beats BUSY_WAIT beats handshake.
    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pc4_d   = main_pc4_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;

        if (FLUSH) begin
            // Redirect: drop everything held and any word arriving this cycle.
            // The PC+4 field is left as is; only the instruction becomes a NOP.
            state_d      = ST_EMPTY;
            main_instr_d = NOP_INSTR;
        end else if (!BUSY_WAIT) begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d      = ST_FULL;
                        main_instr_d = INSTRUCTION;
                        main_pc4_d   = PC_INCREMENT4;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        main_instr_d = INSTRUCTION;
                        main_pc4_d   = PC_INCREMENT4;
                    end else if (in_fire) begin
                        // Decode stalled while fetch still launched: park it.
                        state_d      = ST_SKID;
                        skid_instr_d = INSTRUCTION;
                        skid_pc4_d   = PC_INCREMENT4;
                    end else if (out_fire) begin
                        state_d      = ST_EMPTY;
                        main_instr_d = NOP_INSTR;
                    end
                end
                ST_SKID: begin
                    // IN_READY is low here, so only the drain can happen.
                    if (out_fire) begin
                        state_d      = ST_FULL;
                        main_instr_d = skid_instr_q;
                        main_pc4_d   = skid_pc4_q;
                    end
                end
                default: begin
                    state_d      = ST_EMPTY;
                    main_instr_d = NOP_INSTR;
                end
            endcase
        end
    end

    // Registered handshake outputs are derived from the next state so they
    // line up with the entry they describe.
    always_comb begin
        in_ready_d  = (state_d != ST_SKID);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Bubble counter next value; frozen under BUSY_WAIT and FLUSH.
    always_comb begin
        bubble_d = bubble_q;
        if (bubble_cycle) begin
            bubble_d = sat_inc(bubble_q);
        end
    end

    // Control and main-entry registers, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_instr_q <= NOP_INSTR;
            main_pc4_q   <= RESET_PC4;
            bubble_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_instr_q <= main_instr_d;
            main_pc4_q   <= main_pc4_d;
            bubble_q     <= bubble_d;
        end
    end

    // Skid entry contents; only meaningful while in ST_SKID, so no reset.
    always_ff @(posedge CLK) begin
        skid_instr_q <= skid_instr_d;
        skid_pc4_q   <= skid_pc4_d;
    end

    assign IN_READY          = in_ready_q;
    assign OUT_VALID         = out_valid_q;
    assign INSTRUCTION_OUT   = main_instr_q;
    assign PC_INCREMENT4_OUT = main_pc4_q;
    assign OCCUPANCY         = state_q;
    assign BUBBLE_COUNT      = bubble_q;

endmodule

// File: tb/tb_pipeline_if_id_elastic.sv
// Scoreboard bench for pipeline_if_id_elastic. Accepted words are queued by
// the stimulus; a negedge monitor pops and compares on every output transfer.
// A second instance with a 2-bit counter exercises counter saturation.
module tb_pipeline_if_id_elastic;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        BUSY_WAIT = 1'b0;
    logic        FLUSH = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [31:0] INSTRUCTION = 32'h0;
    logic [31:0] PC_INCREMENT4 = 32'h0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic [31:0] INSTRUCTION_OUT;
    logic [31:0] PC_INCREMENT4_OUT;
    logic [1:0]  OCCUPANCY;
    logic [15:0] BUBBLE_COUNT;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_instr_out;
    logic [31:0] s_pc4_out;
    logic [1:0]  s_occ;
    logic [1:0]  s_bubble;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } entry_t;
    entry_t sb[$];

    always #5 CLK = ~CLK;

    pipeline_if_id_elastic dut (
        .CLK(CLK), .RESET(RESET), .BUSY_WAIT(BUSY_WAIT), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .INSTRUCTION(INSTRUCTION), .PC_INCREMENT4(PC_INCREMENT4),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .INSTRUCTION_OUT(INSTRUCTION_OUT), .PC_INCREMENT4_OUT(PC_INCREMENT4_OUT),
        .OCCUPANCY(OCCUPANCY), .BUBBLE_COUNT(BUBBLE_COUNT)
    );

    pipeline_if_id_elastic #(.CNT_W(2)) dut_sat (
        .CLK(CLK), .RESET(RESET), .BUSY_WAIT(1'b0), .FLUSH(1'b0),
        .IN_VALID(1'b0), .IN_READY(s_in_ready),
        .INSTRUCTION(32'h0), .PC_INCREMENT4(32'h0),
        .OUT_VALID(s_out_valid), .OUT_READY(1'b1),
        .INSTRUCTION_OUT(s_instr_out), .PC_INCREMENT4_OUT(s_pc4_out),
        .OCCUPANCY(s_occ), .BUBBLE_COUNT(s_bubble)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc4);
        IN_VALID      = v;
        INSTRUCTION   = instr;
        PC_INCREMENT4 = pc4;
    endtask

    task automatic expect_word(input logic [31:0] instr, input logic [31:0] pc4);
        entry_t e;
        e.instr = instr;
        e.pc4   = pc4;
        sb.push_back(e);
    endtask

    // Output monitor: a transfer happens at the coming edge when this holds.
    always @(negedge CLK) begin
        if (!RESET && !FLUSH && !BUSY_WAIT && OUT_VALID && OUT_READY) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: unexpected word %08h", INSTRUCTION_OUT);
            end else begin
                entry_t e;
                e = sb.pop_front();
                chk("out_instr", INSTRUCTION_OUT, e.instr);
                chk("out_pc4", PC_INCREMENT4_OUT, e.pc4);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (5000) @(posedge CLK);
        $display("FAIL watchdog: cycle budget expired, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset for two cycles.
        tick();
        tick();
        RESET = 1'b0;
        chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("rst_instr", INSTRUCTION_OUT, 32'h00000013);
        chk("rst_pc4", PC_INCREMENT4_OUT, 32'hFFFFFFFC);
        chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("rst_occ", {30'b0, OCCUPANCY}, 32'd0);
        chk("rst_bubble", {16'b0, BUBBLE_COUNT}, 32'd0);
        chk("rst_sat_bubble", {30'b0, s_bubble}, 32'd0);

        // Five empty cycles: wide counter 1..5, 2-bit counter 1,2,3,3,3.
        tick(); chk("bub1", {16'b0, BUBBLE_COUNT}, 32'd1); chk("sat1", {30'b0, s_bubble}, 32'd1);
        tick(); chk("bub2", {16'b0, BUBBLE_COUNT}, 32'd2); chk("sat2", {30'b0, s_bubble}, 32'd2);
        tick(); chk("bub3", {16'b0, BUBBLE_COUNT}, 32'd3); chk("sat3", {30'b0, s_bubble}, 32'd3);
        tick(); chk("bub4", {16'b0, BUBBLE_COUNT}, 32'd4); chk("sat4", {30'b0, s_bubble}, 32'd3);
        tick(); chk("bub5", {16'b0, BUBBLE_COUNT}, 32'd5); chk("sat5", {30'b0, s_bubble}, 32'd3);

        // Streaming A..D back to back.
        drive(1'b1, 32'hAAAA0001, 32'h4);  expect_word(32'hAAAA0001, 32'h4);  tick();
        chk("strm_valid_a", {31'b0, OUT_VALID}, 32'd1);
        chk("strm_occ_a", {30'b0, OCCUPANCY}, 32'd1);
        drive(1'b1, 32'hBBBB0002, 32'h8);  expect_word(32'hBBBB0002, 32'h8);  tick();
        chk("strm_occ_b", {30'b0, OCCUPANCY}, 32'd1);
        drive(1'b1, 32'hCCCC0003, 32'hC);  expect_word(32'hCCCC0003, 32'hC);  tick();
        chk("strm_occ_c", {30'b0, OCCUPANCY}, 32'd1);
        drive(1'b1, 32'hDDDD0004, 32'h10); expect_word(32'hDDDD0004, 32'h10); tick();
        chk("strm_occ_d", {30'b0, OCCUPANCY}, 32'd1);
        chk("strm_in_ready", {31'b0, IN_READY}, 32'd1);
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("drain_occ", {30'b0, OCCUPANCY}, 32'd0);
        chk("drain_nop", INSTRUCTION_OUT, 32'h00000013);
        chk("drain_pc_hold", PC_INCREMENT4_OUT, 32'h10);
        chk("drain_bubble", {16'b0, BUBBLE_COUNT}, 32'd6);

        // Downstream stall pushes B into the skid entry.
        drive(1'b1, 32'hA2A20005, 32'h14); expect_word(32'hA2A20005, 32'h14); tick();
        OUT_READY = 1'b0;
        drive(1'b1, 32'hB2B20006, 32'h18); expect_word(32'hB2B20006, 32'h18); tick();
        chk("stall_occ", {30'b0, OCCUPANCY}, 32'd2);
        chk("stall_in_ready", {31'b0, IN_READY}, 32'd0);
        chk("stall_instr", INSTRUCTION_OUT, 32'hA2A20005);
        drive(1'b1, 32'hC2C20007, 32'h1C); tick();
        chk("stall_hold_occ", {30'b0, OCCUPANCY}, 32'd2);
        OUT_READY = 1'b1; tick();
        chk("unstall_occ", {30'b0, OCCUPANCY}, 32'd1);
        chk("unstall_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("unstall_instr", INSTRUCTION_OUT, 32'hB2B20006);
        expect_word(32'hC2C20007, 32'h1C); tick();
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("stall_drain_occ", {30'b0, OCCUPANCY}, 32'd0);
        chk("stall_bubble", {16'b0, BUBBLE_COUNT}, 32'd7);

        // BUSY_WAIT freeze mid-stream.
        drive(1'b1, 32'hEEEE0008, 32'h20); expect_word(32'hEEEE0008, 32'h20); tick();
        drive(1'b1, 32'hFFFF0009, 32'h24);
        BUSY_WAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("busy_instr", INSTRUCTION_OUT, 32'hEEEE0008);
            chk("busy_pc4", PC_INCREMENT4_OUT, 32'h20);
            chk("busy_occ", {30'b0, OCCUPANCY}, 32'd1);
            chk("busy_bubble", {16'b0, BUBBLE_COUNT}, 32'd8);
        end
        BUSY_WAIT = 1'b0;
        expect_word(32'hFFFF0009, 32'h24); tick();
        chk("resume_instr", INSTRUCTION_OUT, 32'hFFFF0009);
        drive(1'b1, 32'h1111000A, 32'h28); expect_word(32'h1111000A, 32'h28); tick();
        drive(1'b0, 32'h0, 32'h0); tick();
        chk("busy_end_bubble", {16'b0, BUBBLE_COUNT}, 32'd8);

        // FLUSH in SKID together with BUSY_WAIT and an incoming word.
        drive(1'b1, 32'h2222000B, 32'h30); expect_word(32'h2222000B, 32'h30); tick();
        OUT_READY = 1'b0;
        drive(1'b1, 32'h3333000C, 32'h34); expect_word(32'h3333000C, 32'h34); tick();
        chk("pre_flush_occ", {30'b0, OCCUPANCY}, 32'd2);
        OUT_READY = 1'b1;
        FLUSH     = 1'b1;
        BUSY_WAIT = 1'b1;
        drive(1'b1, 32'h4444000D, 32'h38);
        sb.delete();
        tick();
        FLUSH     = 1'b0;
        BUSY_WAIT = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("flush_occ", {30'b0, OCCUPANCY}, 32'd0);
        chk("flush_valid", {31'b0, OUT_VALID}, 32'd0);
        chk("flush_instr", INSTRUCTION_OUT, 32'h00000013);
        chk("flush_in_ready", {31'b0, IN_READY}, 32'd1);
        chk("flush_pc_hold", PC_INCREMENT4_OUT, 32'h30);
        chk("flush_bubble", {16'b0, BUBBLE_COUNT}, 32'd9);
        tick();
        chk("post_flush_bubble", {16'b0, BUBBLE_COUNT}, 32'd10);
        chk("post_flush_valid", {31'b0, OUT_VALID}, 32'd0);

        tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
